// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage
// Brief    : Operand-fetch stage ahead of the ALU. Register file with
//            write-back bypass feeding one valid/ready pipeline register.
//            Optional macro IMM_SRC_EN adds the immediate operand-2 source.
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
  parameter int DATA_WIDTH = 5,
  parameter int REG_COUNT  = 8,
  parameter int ADDR_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rs1_addr,
  input  logic [ADDR_WIDTH-1:0] in_rs2_addr,
  input  logic [ADDR_WIDTH-1:0] in_rd_addr,
  input  logic [1:0]            in_alu_inst,
`ifdef IMM_SRC_EN
  input  logic                  in_use_imm,
  input  logic [DATA_WIDTH-1:0] in_imm,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_rs1,
  output logic [DATA_WIDTH-1:0] source_2,
  output logic [1:0]            alu_inst,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data
);

  // Register 0 has no storage; it always reads as zero.
  logic [DATA_WIDTH-1:0] rf_q [1:REG_COUNT-1];

  logic [DATA_WIDTH-1:0] rs1_val;
  logic [DATA_WIDTH-1:0] rs2_val;
  logic [DATA_WIDTH-1:0] op2_val;
  logic                  accept;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] data_rs1_q,  data_rs1_d;
  logic [DATA_WIDTH-1:0] source_2_q,  source_2_d;
  logic [1:0]            alu_inst_q,  alu_inst_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q,   rd_addr_d;

  for (genvar i = 1; i < REG_COUNT; i++) begin : g_rf
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rf_q[i] <= '0;
      end else if (wb_en && (wb_addr == ADDR_WIDTH'(i))) begin
        rf_q[i] <= wb_data;
      end
    end
  end

  always_comb begin
    rs1_val = '0;
    if (in_rs1_addr != '0) begin
      if (wb_en && (wb_addr == in_rs1_addr)) begin
        rs1_val = wb_data;
      end else begin
        rs1_val = rf_q[in_rs1_addr];
      end
    end
  end

  always_comb begin
    rs2_val = '0;
    if (in_rs2_addr != '0) begin
      if (wb_en && (wb_addr == in_rs2_addr)) begin
        rs2_val = wb_data;
      end else begin
        rs2_val = rf_q[in_rs2_addr];
      end
    end
  end

`ifdef IMM_SRC_EN
  assign op2_val = in_use_imm ? in_imm : rs2_val;
`else
  assign op2_val = rs2_val;
`endif

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Operands are only captured on accept, so a stall holds them exactly.
  always_comb begin
    out_valid_d = out_valid_q;
    data_rs1_d  = data_rs1_q;
    source_2_d  = source_2_q;
    alu_inst_d  = alu_inst_q;
    rd_addr_d   = rd_addr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      data_rs1_d  = rs1_val;
      source_2_d  = op2_val;
      alu_inst_d  = in_alu_inst;
      rd_addr_d   = in_rd_addr;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      data_rs1_q  <= '0;
      source_2_q  <= '0;
      alu_inst_q  <= '0;
      rd_addr_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      data_rs1_q  <= data_rs1_d;
      source_2_q  <= source_2_d;
      alu_inst_q  <= alu_inst_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_rs1  = data_rs1_q;
  assign source_2  = source_2_q;
  assign alu_inst  = alu_inst_q;
  assign rd_addr   = rd_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_stage
// Brief    : Directed self-checking bench for alu_operand_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

  localparam int DW = 5;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rs1_addr;
  logic [AW-1:0] in_rs2_addr;
  logic [AW-1:0] in_rd_addr;
  logic [1:0]    in_alu_inst;
`ifdef IMM_SRC_EN
  logic          in_use_imm;
  logic [DW-1:0] in_imm;
`endif
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] data_rs1;
  logic [DW-1:0] source_2;
  logic [1:0]    alu_inst;
  logic [AW-1:0] rd_addr;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.DATA_WIDTH(DW), .REG_COUNT(8), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs1_addr (in_rs1_addr),
    .in_rs2_addr (in_rs2_addr),
    .in_rd_addr  (in_rd_addr),
    .in_alu_inst (in_alu_inst),
`ifdef IMM_SRC_EN
    .in_use_imm  (in_use_imm),
    .in_imm      (in_imm),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_rs1    (data_rs1),
    .source_2    (source_2),
    .alu_inst    (alu_inst),
    .rd_addr     (rd_addr),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data)
  );

  // Reference ALU attached to the stage outputs.
  function automatic logic [DW-1:0] alu_model(input logic [1:0] op,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic [1:0] op);
    in_valid    = 1'b1;
    in_rs1_addr = rs1;
    in_rs2_addr = rs2;
    in_rd_addr  = rd;
    in_alu_inst = op;
  endtask

  task automatic wb(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_en   = en;
    wb_addr = a;
    wb_data = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0d expected 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0d expected 1", in_ready); else passed++;
    tick();
    rst_n = 1'b1;
    wb(1'b1, 3'd3, 5'd9);
    tick();
    wb(1'b0, 3'd0, 5'd0);
    out_ready = 1'b0;
    issue(3'd3, 3'd3, 3'd6, 2'b10);
    tick();
    in_valid = 1'b0;
    total++; if (data_rs1 !== 5'd9 || out_valid !== 1'b1) $display("FAIL pre_reset_load: got %0d/%0d expected 9/1", data_rs1, out_valid); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL async_out_valid: got %0d expected 0", out_valid); else passed++;
    total++; if ({data_rs1, source_2, alu_inst, rd_addr} !== '0)
      $display("FAIL async_outputs: got %0d,%0d,%0d,%0d expected 0,0,0,0", data_rs1, source_2, alu_inst, rd_addr); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL async_in_ready: got %0d expected 1", in_ready); else passed++;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    issue(3'd3, 3'd0, 3'd1, 2'b00);
    tick();
    in_valid = 1'b0;
    total++; if (data_rs1 !== 5'd0) $display("FAIL r3_after_reset: got %0d expected 0", data_rs1); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL drain: got %0d expected 0", out_valid); else passed++;
  endtask

  task automatic test_write_read();
    wb(1'b1, 3'd1, 5'd5);
    tick();
    wb(1'b1, 3'd2, 5'd5);
    tick();
    wb(1'b0, 3'd0, 5'd0);
    issue(3'd1, 3'd2, 3'd7, 2'b01);
    tick();
    in_valid = 1'b0;
    total++; if (data_rs1 !== 5'd5) $display("FAIL wr_rs1: got %0d expected 5", data_rs1); else passed++;
    total++; if (source_2 !== 5'd5) $display("FAIL wr_rs2: got %0d expected 5", source_2); else passed++;
    total++; if (alu_inst !== 2'b01 || rd_addr !== 3'd7) $display("FAIL wr_ctrl: got %0d/%0d expected 1/7", alu_inst, rd_addr); else passed++;
    total++; if (alu_model(alu_inst, data_rs1, source_2) !== 5'd0) $display("FAIL wr_alu_zero: got %0d expected 0", alu_model(alu_inst, data_rs1, source_2)); else passed++;
    tick();
  endtask

  task automatic test_bypass();
    wb(1'b1, 3'd4, 5'd7);
    issue(3'd4, 3'd0, 3'd2, 2'b00);
    tick();
    total++; if (data_rs1 !== 5'd7) $display("FAIL bypass_rs1: got %0d expected 7", data_rs1); else passed++;
    total++; if (source_2 !== 5'd0) $display("FAIL bypass_r0: got %0d expected 0", source_2); else passed++;
    wb(1'b1, 3'd5, 5'd12);
    issue(3'd0, 3'd5, 3'd2, 2'b11);
    tick();
    total++; if (source_2 !== 5'd12) $display("FAIL bypass_rs2: got %0d expected 12", source_2); else passed++;
    wb(1'b0, 3'd0, 5'd0);
    issue(3'd4, 3'd5, 3'd2, 2'b11);
    tick();
    in_valid = 1'b0;
    total++; if (data_rs1 !== 5'd7 || source_2 !== 5'd12) $display("FAIL bypass_stored: got %0d/%0d expected 7/12", data_rs1, source_2); else passed++;
    tick();
  endtask

  task automatic test_reg0();
    wb(1'b1, 3'd0, 5'd3);
    tick();
    issue(3'd0, 3'd0, 3'd1, 2'b00);
    tick();
    total++; if (data_rs1 !== 5'd0) $display("FAIL r0_same_cycle: got %0d expected 0", data_rs1); else passed++;
    wb(1'b0, 3'd0, 5'd0);
    tick();
    in_valid = 1'b0;
    total++; if (data_rs1 !== 5'd0) $display("FAIL r0_stored: got %0d expected 0", data_rs1); else passed++;
    tick();
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    issue(3'd1, 3'd2, 3'd2, 2'b10);
    tick();
    issue(3'd4, 3'd5, 3'd3, 2'b11);
    wb(1'b1, 3'd1, 5'd20);
    for (int i = 0; i < 3; i++) begin
      total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d]: got %0d expected 0", i, in_ready); else passed++;
      total++; if (data_rs1 !== 5'd5 || rd_addr !== 3'd2 || out_valid !== 1'b1)
        $display("FAIL stall_hold[%0d]: got %0d/%0d/%0d expected 5/2/1", i, data_rs1, rd_addr, out_valid); else passed++;
      tick();
      wb(1'b0, 3'd0, 5'd0);
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %0d expected 1", in_ready); else passed++;
    tick();
    in_valid = 1'b0;
    total++; if (data_rs1 !== 5'd7 || source_2 !== 5'd12 || rd_addr !== 3'd3 || out_valid !== 1'b1)
      $display("FAIL release_accept: got %0d/%0d/%0d/%0d expected 7/12/3/1", data_rs1, source_2, rd_addr, out_valid); else passed++;
    tick();
    total++; if (out_valid !== 1'b0 || data_rs1 !== 5'd7) $display("FAIL release_drain: got %0d/%0d expected 0/7", out_valid, data_rs1); else passed++;
    issue(3'd1, 3'd0, 3'd1, 2'b00);
    tick();
    in_valid = 1'b0;
    total++; if (data_rs1 !== 5'd20) $display("FAIL stall_wb_written: got %0d expected 20", data_rs1); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] rs [3];
    logic [DW-1:0] ex [3];
    rs[0] = 3'd1; rs[1] = 3'd4; rs[2] = 3'd5;
    ex[0] = 5'd20; ex[1] = 5'd7; ex[2] = 5'd12;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(rs[i], 3'd0, 3'(i), 2'b00);
      tick();
      total++; if (out_valid !== 1'b1 || data_rs1 !== ex[i] || rd_addr !== 3'(i))
        $display("FAIL b2b[%0d]: got %0d/%0d/%0d expected 1/%0d/%0d", i, out_valid, data_rs1, rd_addr, ex[i], i); else passed++;
    end
    in_valid = 1'b0;
    tick();
  endtask

`ifdef IMM_SRC_EN
  task automatic test_imm();
    wb(1'b1, 3'd1, 5'd2);
    tick();
    wb(1'b0, 3'd0, 5'd0);
    in_use_imm = 1'b1;
    in_imm     = 5'd3;
    issue(3'd1, 3'd2, 3'd4, 2'b00);
    tick();
    in_valid   = 1'b0;
    in_use_imm = 1'b0;
    total++; if (source_2 !== 5'd3) $display("FAIL imm_src2: got %0d expected 3", source_2); else passed++;
    total++; if (alu_model(alu_inst, data_rs1, source_2) !== 5'd5) $display("FAIL imm_alu: got %0d expected 5", alu_model(alu_inst, data_rs1, source_2)); else passed++;
    tick();
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    issue(3'd0, 3'd0, 3'd0, 2'b00);
    in_valid  = 1'b0;
    wb(1'b0, 3'd0, 5'd0);
`ifdef IMM_SRC_EN
    in_use_imm = 1'b0;
    in_imm     = '0;
`endif
    test_reset();
    test_write_read();
    test_bypass();
    test_reg0();
    test_back_pressure();
    test_back_to_back();
`ifdef IMM_SRC_EN
    test_imm();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
